// File: rtl/uart_echo_checker.sv
// Far-end self-test initiator for a UART rx->tx echo loop: sends an incrementing 8N1
// byte stream, checks each echoed byte against the byte sent, reports errors/timeout/pass.
module uart_echo_checker #(
  parameter logic [23:0] BAUD_RATE    = 24'd9600,
  parameter logic [27:0] CLOCK_FREQ   = 28'd100000000,
  parameter logic [7:0]  TIMEOUT_BITS = 8'd20
) (
  input  logic       clk_int,
  input  logic       uart_reset,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [7:0] byte_count,
  input  logic       rx_d_in,
  output logic       tx_d_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [7:0] err_count,
  output logic [7:0] last_rx_byte
);

  localparam int BIT_CYC = int'(CLOCK_FREQ / BAUD_RATE);
  localparam int LIMIT   = (10 + int'(TIMEOUT_BITS)) * BIT_CYC;
  localparam int CW      = $clog2(BIT_CYC + 1);
  localparam int TW      = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYC / 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(LIMIT - 1);

  typedef enum logic [2:0] {C_IDLE, C_SEND, C_WAIT, C_CHECK, C_DONE} ctl_t;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_t;

  // Receive side
  logic          rx_s1, rx_s2, rx_prev;
  ser_t          rx_state;
  logic [CW-1:0] rx_cyc;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift, rx_data;
  logic          rx_valid, rx_frame_ok;

  // Transmit / control side
  ctl_t          ctl;
  ser_t          tx_state;
  logic [CW-1:0] tx_cyc;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift, cur_byte, kick_byte;
  logic [8:0]    total, sent;
  logic [TW-1:0] to_cnt;
  logic          accept, kick, rx_take, to_expire, stop_late;

  assign accept    = start && !busy;
  assign kick      = accept || (ctl == C_CHECK && sent != total && tx_state == S_IDLE);
  assign kick_byte = accept ? seed : cur_byte + 8'd1;
  // An echo may legitimately complete while our own stop bit is still on the line.
  assign stop_late = (tx_state == S_STOP) && (tx_cyc >= CYC_HALF);
  assign rx_take   = rx_valid && ((ctl == C_WAIT) || (ctl == C_SEND && stop_late));
  assign to_expire = (ctl == C_SEND || ctl == C_WAIT) && (to_cnt == TO_LAST) && !rx_take;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order within or across blocks.
  always_ff @(posedge clk_int or posedge uart_reset) begin
    if (uart_reset) begin
      rx_s1       <= 1'b1;
      rx_s2       <= 1'b1;
      rx_prev     <= 1'b1;
      rx_state    <= S_IDLE;
      rx_cyc      <= '0;
      rx_bit      <= '0;
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_frame_ok <= 1'b0;
    end else begin
      rx_s1    <= rx_d_in;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      if (!busy) begin
        rx_state <= S_IDLE;
        rx_cyc   <= '0;
      end else begin
        case (rx_state)
          S_IDLE: if (rx_prev && !rx_s2) begin
            rx_state <= S_START;
            rx_cyc   <= '0;
          end
          S_START: if (rx_cyc == CYC_HALF) begin
            rx_cyc   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else rx_cyc <= rx_cyc + 1'b1;
          S_DATA: if (rx_cyc == CYC_LAST) begin
            rx_cyc   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else rx_cyc <= rx_cyc + 1'b1;
          S_STOP: if (rx_cyc == CYC_LAST) begin
            rx_cyc      <= '0;
            rx_valid    <= 1'b1;
            rx_frame_ok <= rx_s2;
            rx_data     <= rx_shift;
            rx_state    <= S_IDLE;
          end else rx_cyc <= rx_cyc + 1'b1;
          default: rx_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_int or posedge uart_reset) begin
    if (uart_reset) begin
      ctl          <= C_IDLE;
      tx_state     <= S_IDLE;
      tx_d_out     <= 1'b1;
      tx_cyc       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      cur_byte     <= '0;
      total        <= '0;
      sent         <= '0;
      to_cnt       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      err_count    <= '0;
      last_rx_byte <= '0;
    end else begin
      if (rx_valid) last_rx_byte <= rx_data;

      if (accept) begin
        busy      <= 1'b1;
        done      <= 1'b0;
        pass      <= 1'b0;
        timeout   <= 1'b0;
        err_count <= '0;
        total     <= (byte_count == 8'd0) ? 9'd256 : {1'b0, byte_count};
        sent      <= 9'd1;
        ctl       <= C_SEND;
      end else begin
        case (ctl)
          C_SEND, C_WAIT: begin
            if (rx_take) begin
              if ((rx_data != cur_byte || !rx_frame_ok) && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
              ctl <= C_CHECK;
            end else if (to_expire) begin
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              timeout <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= 1'b0;
              ctl     <= C_DONE;
            end else begin
              to_cnt <= to_cnt + 1'b1;
              if (ctl == C_SEND && tx_state == S_IDLE) ctl <= C_WAIT;
            end
          end
          C_CHECK: begin
            if (sent == total) begin
              busy <= 1'b0;
              done <= 1'b1;
              pass <= (err_count == 8'd0);
              ctl  <= C_DONE;
            end else if (tx_state == S_IDLE) begin
              sent <= sent + 9'd1;
              ctl  <= C_SEND;
            end
          end
          default: ;
        endcase
      end

      if (kick) begin
        tx_state <= S_START;
        tx_d_out <= 1'b0;
        tx_cyc   <= '0;
        tx_shift <= kick_byte;
        cur_byte <= kick_byte;
        to_cnt   <= '0;
      end else begin
        case (tx_state)
          S_START: if (tx_cyc == CYC_LAST) begin
            tx_cyc   <= '0;
            tx_bit   <= '0;
            tx_d_out <= tx_shift[0];
            tx_state <= S_DATA;
          end else tx_cyc <= tx_cyc + 1'b1;
          S_DATA: if (tx_cyc == CYC_LAST) begin
            tx_cyc <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= S_STOP;
              tx_d_out <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_d_out <= tx_shift[1];
            end
          end else tx_cyc <= tx_cyc + 1'b1;
          S_STOP: if (tx_cyc == CYC_LAST) begin
            tx_cyc   <= '0;
            tx_state <= S_IDLE;
          end else tx_cyc <= tx_cyc + 1'b1;
          default: tx_d_out <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
// Bench for uart_echo_checker: a delay-line echo far end with optional bit corruption and
// line glitches, a frame monitor on tx_d_out, and expectations from seed/count arithmetic.
module tb_uart_echo_checker;

  localparam int BIT_CYC = 16;
  localparam int FRAME   = 10 * BIT_CYC;

  logic       clk_int    = 1'b0;
  logic       uart_reset = 1'b1;
  logic       start      = 1'b0;
  logic [7:0] seed       = 8'd0;
  logic [7:0] byte_count = 8'd0;
  logic       rx_d_in    = 1'b1;
  logic       tx_d_out, busy, done, pass, timeout;
  logic [7:0] err_count, last_rx_byte;

  int vectors     = 0;
  int miscompares = 0;

  uart_echo_checker #(
    .BAUD_RATE   (24'd100),
    .CLOCK_FREQ  (28'd1600),
    .TIMEOUT_BITS(8'd20)
  ) dut (
    .clk_int     (clk_int),
    .uart_reset  (uart_reset),
    .start       (start),
    .seed        (seed),
    .byte_count  (byte_count),
    .rx_d_in     (rx_d_in),
    .tx_d_out    (tx_d_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .timeout     (timeout),
    .err_count   (err_count),
    .last_rx_byte(last_rx_byte)
  );

  always #5 clk_int = ~clk_int;

  // Far-end model configuration
  bit           echo_en     = 1'b1;
  int           echo_delay  = 4;
  int           corrupt_idx = -1;
  int           frame_base  = 0;
  bit           glitch_en   = 1'b0;
  logic [511:0] dline       = '1;

  // tx frame monitor and delayed-echo frame tracker
  logic [7:0] tx_log [0:2047];
  int         tx_n    = 0;
  int         tx_pos  = 0;
  bit         tx_act  = 1'b0;
  logic       tx_prev = 1'b1;
  logic [7:0] tx_sh   = 8'd0;
  int         d_pos   = 0;
  bit         d_act   = 1'b0;
  logic       d_prev  = 1'b1;
  int         d_frames = 0;
  logic       dl, flip, line_out;

  initial begin
    forever begin
      @(negedge clk_int);
      dline = {dline[510:0], tx_d_out};
      dl    = dline[echo_delay-1];

      if ((!tx_act || tx_pos >= FRAME - 1) && tx_prev && !tx_d_out) begin
        tx_act = 1'b1;
        tx_pos = 0;
      end else if (tx_act && tx_pos < 1000) tx_pos++;
      if (tx_act && tx_pos == 8 && tx_d_out) tx_act = 1'b0;
      if (tx_act && tx_pos >= 24 && tx_pos <= 136 && (tx_pos - 24) % 16 == 0)
        tx_sh = {tx_d_out, tx_sh[7:1]};
      if (tx_act && tx_pos == 152) begin
        tx_log[tx_n % 2048] = tx_sh;
        tx_n++;
      end

      if ((!d_act || d_pos >= FRAME - 1) && d_prev && !dl) begin
        d_act = 1'b1;
        d_pos = 0;
        d_frames++;
      end else if (d_act && d_pos < 1000) d_pos++;
      flip = d_act && (d_frames - 1 - frame_base == corrupt_idx) && d_pos >= 16 && d_pos < 32;
      line_out = echo_en ? (dl ^ flip) : 1'b1;
      if (glitch_en && tx_act && tx_pos >= FRAME + 10 && tx_pos < FRAME + 13) line_out = 1'b0;
      rx_d_in = line_out;
      tx_prev = tx_d_out;
      d_prev  = dl;
    end
  end

  // Pulse start for one cycle; called at a negedge, returns at the negedge after acceptance.
  task automatic kick_run(input logic [7:0] s, input logic [7:0] n, output int base);
    base       = tx_n;
    frame_base = d_frames;
    start      = 1'b1;
    seed       = s;
    byte_count = n;
    @(negedge clk_int);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk_int);
      cycles++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_int);
    vectors++;
    if ({tx_d_out, busy, done, pass, timeout} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 10000", {tx_d_out, busy, done, pass, timeout});
    end
    vectors++;
    if ({err_count, last_rx_byte} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_counts: got %h want 0000", {err_count, last_rx_byte});
    end
    uart_reset = 1'b0;
    repeat (3) @(negedge clk_int);
    vectors++;
    if ({tx_d_out, busy, done} !== 3'b100) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %b want 100", {tx_d_out, busy, done});
    end
  endtask

  task automatic test_basic();
    int base, cyc;
    kick_run(8'h41, 8'd4, base);
    vectors++;
    if ({busy, done, tx_d_out} !== 3'b100) begin
      miscompares++;
      $display("FAIL basic_start: got %b want 100", {busy, done, tx_d_out});
    end
    wait_done(3000, cyc);
    vectors++;
    if ({done, busy, pass, timeout} !== 4'b1010) begin
      miscompares++;
      $display("FAIL basic_status: got %b want 1010", {done, busy, pass, timeout});
    end
    vectors++;
    if (err_count !== 8'd0 || last_rx_byte !== 8'h44) begin
      miscompares++;
      $display("FAIL basic_err_last: got %h/%h want 00/44", err_count, last_rx_byte);
    end
    vectors++;
    if (tx_n - base !== 4) begin
      miscompares++;
      $display("FAIL basic_count: got %0d want 4", tx_n - base);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (tx_log[(base + k) % 2048] !== 8'(8'h41 + k)) begin
        miscompares++;
        $display("FAIL basic_byte%0d: got %h want %h", k, tx_log[(base + k) % 2048], 8'(8'h41 + k));
      end
    end
    repeat (5) @(negedge clk_int);
    vectors++;
    if (tx_d_out !== 1'b1 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_hold: got tx=%b done=%b want 1/1", tx_d_out, done);
    end
  endtask

  task automatic test_corrupt();
    int base, cyc;
    logic [7:0] s;
    s = 8'($urandom);
    corrupt_idx = 2;
    kick_run(s, 8'd4, base);
    wait_done(3000, cyc);
    corrupt_idx = -1;
    vectors++;
    if ({done, pass, timeout} !== 3'b100 || err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL corrupt_status: got d/p/t=%b err=%h want 100 01", {done, pass, timeout}, err_count);
    end
    vectors++;
    if (last_rx_byte !== 8'(s + 3)) begin
      miscompares++;
      $display("FAIL corrupt_last: got %h want %h", last_rx_byte, 8'(s + 3));
    end
    vectors++;
    if (tx_n - base !== 4) begin
      miscompares++;
      $display("FAIL corrupt_count: got %0d want 4", tx_n - base);
    end
  endtask

  task automatic test_timeout();
    int base, cyc;
    logic [7:0] s;
    s = 8'($urandom);
    echo_en = 1'b0;
    kick_run(s, 8'd3, base);
    wait_done(2000, cyc);
    vectors++;
    if (cyc < 30 * BIT_CYC - 3 || cyc > 30 * BIT_CYC + 3 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d cycles done=%b want %0d", cyc, done, 30 * BIT_CYC);
    end
    vectors++;
    if ({timeout, pass, busy} !== 3'b100 || err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL timeout_status: got t/p/b=%b err=%h want 100 01", {timeout, pass, busy}, err_count);
    end
    vectors++;
    if (tx_n - base !== 1 || tx_log[base % 2048] !== s) begin
      miscompares++;
      $display("FAIL timeout_sent: got %0d bytes first=%h want 1 %h", tx_n - base, tx_log[base % 2048], s);
    end
    echo_en = 1'b1;
    repeat (20) @(negedge clk_int);
  endtask

  task automatic test_wrap();
    int base, cyc;
    kick_run(8'hFE, 8'd0, base);
    wait_done(60000, cyc);
    vectors++;
    if ({done, pass, timeout} !== 3'b110 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL wrap_status: got d/p/t=%b err=%h want 110 00", {done, pass, timeout}, err_count);
    end
    vectors++;
    if (tx_n - base !== 256) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d want 256", tx_n - base);
    end
    for (int k = 0; k < 256; k++) begin
      vectors++;
      if (tx_log[(base + k) % 2048] !== 8'(8'hFE + k)) begin
        miscompares++;
        $display("FAIL wrap_byte%0d: got %h want %h", k, tx_log[(base + k) % 2048], 8'(8'hFE + k));
      end
    end
  endtask

  task automatic test_glitch();
    int base, cyc;
    logic [7:0] s;
    s = 8'($urandom);
    repeat (600) @(negedge clk_int);
    echo_delay = 200;
    glitch_en  = 1'b1;
    kick_run(s, 8'd3, base);
    wait_done(5000, cyc);
    glitch_en = 1'b0;
    vectors++;
    if ({done, pass, timeout} !== 3'b110 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL glitch_status: got d/p/t=%b err=%h want 110 00", {done, pass, timeout}, err_count);
    end
    vectors++;
    if (tx_n - base !== 3 || last_rx_byte !== 8'(s + 2)) begin
      miscompares++;
      $display("FAIL glitch_stream: got %0d bytes last=%h want 3 %h", tx_n - base, last_rx_byte, 8'(s + 2));
    end
    repeat (600) @(negedge clk_int);
    echo_delay = 4;
  endtask

  task automatic test_back_to_back();
    int base1, base2, cyc, n1, n2;
    logic [7:0] s1, s2;
    s1 = 8'($urandom);
    s2 = 8'($urandom);
    n1 = $urandom_range(2, 4);
    n2 = $urandom_range(2, 4);
    kick_run(s1, 8'(n1), base1);
    wait_done(3000, cyc);
    vectors++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got done=%b pass=%b want 1/1", done, pass);
    end
    kick_run(s2, 8'(n2), base2);
    vectors++;
    if ({busy, done, tx_d_out} !== 3'b100) begin
      miscompares++;
      $display("FAIL b2b_accept: got %b want 100", {busy, done, tx_d_out});
    end
    wait_done(3000, cyc);
    vectors++;
    if (pass !== 1'b1 || tx_n - base2 !== n2) begin
      miscompares++;
      $display("FAIL b2b_second: got pass=%b bytes=%0d want 1 %0d", pass, tx_n - base2, n2);
    end
    for (int k = 0; k < n2; k++) begin
      vectors++;
      if (tx_log[(base2 + k) % 2048] !== 8'(s2 + k)) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: got %h want %h", k, tx_log[(base2 + k) % 2048], 8'(s2 + k));
      end
    end
  endtask

  task automatic test_reset_abort();
    int base, cyc;
    logic [7:0] s;
    s = 8'($urandom);
    kick_run(8'($urandom), 8'd4, base);
    repeat (50) @(negedge clk_int);
    uart_reset = 1'b1;
    #1;
    vectors++;
    if (tx_d_out !== 1'b1 || busy !== 1'b0 || err_count !== 8'd0) begin
      miscompares++;
      $display("FAIL abort_immediate: got tx=%b busy=%b err=%h want 1 0 00", tx_d_out, busy, err_count);
    end
    @(negedge clk_int);
    uart_reset = 1'b0;
    repeat (600) @(negedge clk_int);
    kick_run(s, 8'd3, base);
    repeat (40) @(negedge clk_int);
    start      = 1'b1;
    seed       = ~s;
    byte_count = 8'd1;
    @(negedge clk_int);
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy_start: got busy=%b done=%b want 1/0", busy, done);
    end
    wait_done(3000, cyc);
    vectors++;
    if ({done, pass} !== 2'b11 || tx_n - base !== 3) begin
      miscompares++;
      $display("FAIL abort_rerun: got d/p=%b bytes=%0d want 11 3", {done, pass}, tx_n - base);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (tx_log[(base + k) % 2048] !== 8'(s + k)) begin
        miscompares++;
        $display("FAIL abort_byte%0d: got %h want %h", k, tx_log[(base + k) % 2048], 8'(s + k));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corrupt();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
